mc_datapath_p: RTL and testbench
================================

Name: mc_datapath_p

Overview:
Parametrised multicycle ARM-subset datapath, the successor to the fixed 32-bit multicycle datapath. It holds the PC, IR, data and operand registers, ALUOut and a 15-entry register file, plus the ALU and immediate extender. It is driven cycle by cycle by the existing multicycle controller FSM. Additions over the previous generation:
- Parametric data width.
- Programmable reset PC.
- 3-bit ALU opcode with EOR/MOV.
- 4-way SrcA/SrcB/Result selection.
- Reset of all architectural state.

Parameters:
- DW, 32, data/address width; legal values 32 or 64. Instr is always 32 bits.
- RESET_PC, 0, PC value loaded on reset (DW bits, word aligned).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- Adr  out  DW  memory address
- WriteData  out  DW  store data, register copy of RD2
- ReadData  in  DW  memory read data
- Instr  out  32  instruction register contents
- ALUFlags  out  4  {N,Z,C,V} of the current ALUResult (combinational)
- PCWrite  in  1  PC load enable
- RegWrite  in  1  register file write enable
- IRWrite  in  1  IR load enable
- AdrSrc  in  1  0: Adr=PC, 1: Adr=Result
- RegSrc  in  2  [0]: RA1=15; [1]: RA2=Instr[15:12]
- ALUSrcA  in  2  SrcA select
- ALUSrcB  in  2  SrcB select
- ResultSrc  in  2  Result select
- ImmSrc  in  2  extender mode
- ALUControl  in  3  ALU operation

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - PC=RESET_PC; IR=0; Data, A, WriteData, ALUOut=0; R0-R14=0.
  - Outputs in the cycle after reset: Instr=0, WriteData=0, Adr=RESET_PC if AdrSrc=0.
  - Reset wins over every enable in the same cycle.
- State registers:
  - PC <= Result when PCWrite.
  - IR <= ReadData[31:0] when IRWrite.
  - Unconditional every cycle: Data <= ReadData; A <= RD1; WriteData <= RD2; ALUOut <= ALUResult.
- Register file:
  - RA1 = RegSrc[0] ? 4'd15 : Instr[19:16].
  - RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
  - Reads are combinational. Reading index 15 returns Result; there is no physical R15.
  - Write at the rising edge when RegWrite, WA3=Instr[15:12], WD3=Result. A write to index 15 is ignored; the PC is updated only via PCWrite.
  - Same-cycle read of a register being written returns the old value.
- Extender (ImmSrc):
  - 00: zero-extend Instr[7:0].
  - 01: zero-extend Instr[11:0].
  - 10: sign-extend {Instr[23:0],2'b00} to DW.
  - 11: zero.
- SrcA (ALUSrcA): 00 A, 01 PC, 10 ALUOut, 11 zero.
- SrcB (ALUSrcB): 00 WriteData, 01 ExtImm, 10 constant 4, 11 zero.
- ALU (ALUControl):
  - 000 ADD, 001 SUB (SrcA-SrcB), 010 AND, 011 ORR, 100 EOR, 101 MOV (=SrcB); 110/111 produce 0.
  - All arithmetic is modulo 2^DW.
- Flags:
  - N = ALUResult[DW-1]; Z = (ALUResult==0).
  - C = carry-out for ADD; C = NOT borrow for SUB.
  - V = signed overflow for ADD/SUB.
  - C=V=0 for every other op.
- Result (ResultSrc): 00 ALUOut, 01 Data, 10 ALUResult, 11 ALUOut.
- Adr = AdrSrc ? Result : PC.
- Latencies:
  - Memory data reaches Result via Data one cycle after ReadData is presented.
  - Register operands reach A/WriteData one cycle after RA is set.
- Mid-operation reset: any partially executed instruction is discarded; there is no residual state.

Optional Feature:
- SHIFT_EN defined: a barrel shifter sits on the ALUSrcB=00 path when Instr[25]=0.
  - Shift type Instr[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - Shift amount Instr[11:7]; amount 0 means no shift for every type.
  - The shifter carry-out is not reported in ALUFlags.
- SHIFT_EN undefined: SrcB=WriteData unshifted; no shifter logic is instantiated.

Test Plan:
- Reset with RESET_PC=0x100, AdrSrc=0 -> Adr=0x100, Instr=0, WriteData=0; a RegWrite asserted during reset writes nothing.
- Fetch: ReadData=0xE2802005, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1 -> next cycle Instr=0xE2802005, PC=0x104.
- ADD immediate: R0=7 preloaded, execute Instr=0xE2802005 (ADD R2,R0,#5), ImmSrc=00, ALUSrcB=01, then writeback ResultSrc=00, RegWrite=1 -> R2=12, flags NZCV=0000.
- SUB to zero: A=5, SrcB=5, ALUControl=001 -> ALUResult=0, NZCV=0110. Separately, 0x7FFFFFFF+1 ADD -> NZCV=1001.
- Load path: AdrSrc=1 with Result=0x200, ReadData=0xDEADBEEF -> Data=0xDEADBEEF next cycle; ResultSrc=01 with RegWrite writes it into R[Instr[15:12]]. A write with Instr[15:12]=15 leaves PC unchanged.
- SHIFT_EN: WriteData=0x80000000, Instr[6:5]=10, Instr[11:7]=4, ALUControl=101 -> ALUResult=0xF8000000. Without SHIFT_EN -> 0x80000000.

Source files
------------

// File: rtl/mc_datapath_p_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_datapath_p_if : memory bus and controller signals of the datapath  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface mc_datapath_p_if #(
  parameter int unsigned DW = 32
);
  logic [DW-1:0] Adr;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;
  logic [31:0]   Instr;
  logic [3:0]    ALUFlags;
  logic          PCWrite;
  logic          RegWrite;
  logic          IRWrite;
  logic          AdrSrc;
  logic [1:0]    RegSrc;
  logic [1:0]    ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic [1:0]    ResultSrc;
  logic [1:0]    ImmSrc;
  logic [2:0]    ALUControl;

  // Controller and memory side
  modport master (
    input  Adr, WriteData, Instr, ALUFlags,
    output ReadData, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  // Datapath side
  modport slave (
    output Adr, WriteData, Instr, ALUFlags,
    input  ReadData, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface
`default_nettype wire

// File: rtl/mc_datapath_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_datapath_p : parametrised multicycle ARM-subset datapath           |
// | Optional macro SHIFT_EN adds a barrel shifter on the register SrcB.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mc_datapath_p #(
  parameter int unsigned   DW       = 32,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  mc_datapath_p_if.slave bus
);

  localparam logic [3:0]  C_PC_IDX = 4'd15;
  localparam int unsigned C_NREGS  = 15;

  logic [DW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [DW-1:0] data_q, a_q, wd_q, aluout_q;
  logic [DW-1:0] rf_q [C_NREGS];

  logic [3:0]    w_ra1, w_ra2, w_wa3;
  logic          w_rf_we;
  logic [DW-1:0] w_rd1, w_rd2, w_ext, w_wdsh, w_srca, w_srcb;
  logic [DW-1:0] w_alu, w_result;
  logic [DW:0]   w_sum;
  logic          w_c, w_v;

  assign w_ra1   = bus.RegSrc[0] ? C_PC_IDX : ir_q[19:16];
  assign w_ra2   = bus.RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
  assign w_wa3   = ir_q[15:12];
  assign w_rf_we = bus.RegWrite && (w_wa3 != C_PC_IDX);

  // Index 15 aliases Result; there is no physical R15
  assign w_rd1 = (w_ra1 == C_PC_IDX) ? w_result : rf_q[w_ra1];
  assign w_rd2 = (w_ra2 == C_PC_IDX) ? w_result : rf_q[w_ra2];

  always_comb begin
    case (bus.ImmSrc)
      2'b00:   w_ext = {{(DW-8){1'b0}}, ir_q[7:0]};
      2'b01:   w_ext = {{(DW-12){1'b0}}, ir_q[11:0]};
      2'b10:   w_ext = {{(DW-26){ir_q[23]}}, ir_q[23:0], 2'b00};
      default: w_ext = '0;
    endcase
  end

`ifdef SHIFT_EN
  logic [4:0] w_shamt;
  logic [1:0] w_shtyp;

  assign w_shamt = ir_q[11:7];
  assign w_shtyp = ir_q[6:5];

  always_comb begin
    w_wdsh = wd_q;
    if (!ir_q[25] && (w_shamt != 5'd0)) begin
      case (w_shtyp)
        2'b00:   w_wdsh = wd_q << w_shamt;
        2'b01:   w_wdsh = wd_q >> w_shamt;
        2'b10:   w_wdsh = $signed(wd_q) >>> w_shamt;
        default: w_wdsh = (wd_q >> w_shamt) | (wd_q << (DW - w_shamt));
      endcase
    end
  end
`else
  assign w_wdsh = wd_q;
`endif

  always_comb begin
    case (bus.ALUSrcA)
      2'b00:   w_srca = a_q;
      2'b01:   w_srca = pc_q;
      2'b10:   w_srca = aluout_q;
      default: w_srca = '0;
    endcase
    case (bus.ALUSrcB)
      2'b00:   w_srcb = w_wdsh;
      2'b01:   w_srcb = w_ext;
      2'b10:   w_srcb = DW'(4);
      default: w_srcb = '0;
    endcase
  end

  always_comb begin
    w_sum = '0;
    w_alu = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.ALUControl)
      3'b000: begin
        w_sum = {1'b0, w_srca} + {1'b0, w_srcb};
        w_alu = w_sum[DW-1:0];
        w_c   = w_sum[DW];
        w_v   = (w_srca[DW-1] == w_srcb[DW-1]) && (w_alu[DW-1] != w_srca[DW-1]);
      end
      3'b001: begin
        // C is the carry of A + ~B + 1, i.e. NOT borrow
        w_sum = {1'b0, w_srca} + {1'b0, ~w_srcb} + {{DW{1'b0}}, 1'b1};
        w_alu = w_sum[DW-1:0];
        w_c   = w_sum[DW];
        w_v   = (w_srca[DW-1] != w_srcb[DW-1]) && (w_alu[DW-1] != w_srca[DW-1]);
      end
      3'b010:  w_alu = w_srca & w_srcb;
      3'b011:  w_alu = w_srca | w_srcb;
      3'b100:  w_alu = w_srca ^ w_srcb;
      3'b101:  w_alu = w_srcb;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    case (bus.ResultSrc)
      2'b01:   w_result = data_q;
      2'b10:   w_result = w_alu;
      default: w_result = aluout_q;
    endcase
  end

  assign pc_d = bus.PCWrite ? w_result : pc_q;
  assign ir_d = bus.IRWrite ? bus.ReadData[31:0] : ir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      data_q   <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      aluout_q <= '0;
      for (int i = 0; i < C_NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      data_q   <= bus.ReadData;
      a_q      <= w_rd1;
      wd_q     <= w_rd2;
      aluout_q <= w_alu;
      if (w_rf_we) begin
        rf_q[w_wa3] <= w_result;
      end
    end
  end

  assign bus.Adr       = bus.AdrSrc ? w_result : pc_q;
  assign bus.WriteData = wd_q;
  assign bus.Instr     = ir_q;
  assign bus.ALUFlags  = {w_alu[DW-1], (w_alu == '0), w_c, w_v};

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_datapath_p : directed self-checking bench for mc_datapath_p     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mc_datapath_p;

  localparam int unsigned   DW       = 32;
  localparam logic [DW-1:0] RESET_PC = 32'h0000_0100;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_sh;

  mc_datapath_p_if #(.DW(DW)) bus ();

  mc_datapath_p #(
    .DW       (DW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.RegSrc     = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.ALUControl = 3'b000;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive ALU result onto Adr through ResultSrc=ALUResult, AdrSrc=Result
  task automatic alu_view(input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] op);
    bus.ALUSrcA    = sa;
    bus.ALUSrcB    = sb;
    bus.ALUControl = op;
    bus.ResultSrc  = 2'b10;
    bus.AdrSrc     = 1'b1;
    settle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef SHIFT_EN
    exp_sh = 32'hF800_0000;
`else
    exp_sh = 32'h8000_0000;
`endif
    idle();
    bus.ReadData = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("rst_adr",   bus.Adr,       32'h100);
    chk("rst_instr", bus.Instr,     32'h0);
    chk("rst_wd",    bus.WriteData, 32'h0);
    chk("rst_flags", bus.ALUFlags,  4'b0100);

    // R0 = 7 through the Data register
    bus.ReadData = 32'd7;
    tick();
    bus.ResultSrc = 2'b01;
    bus.AdrSrc    = 1'b1;
    bus.RegWrite  = 1'b1;
    settle();
    chk("data_path", bus.Adr, 32'd7);
    tick();
    idle();
    tick();
    chk("wd_r0", bus.WriteData, 32'd7);

    // Fetch: IR <= ReadData, PC <= PC + 4
    bus.ReadData   = 32'hE280_2005;
    bus.IRWrite    = 1'b1;
    bus.PCWrite    = 1'b1;
    bus.ALUSrcA    = 2'b01;
    bus.ALUSrcB    = 2'b10;
    bus.ResultSrc  = 2'b10;
    settle();
    chk("fetch_flags", bus.ALUFlags, 4'b0000);
    tick();
    idle();
    settle();
    chk("fetch_instr", bus.Instr, 32'hE280_2005);
    chk("fetch_pc",    bus.Adr,   32'h104);

    // ADD R2, R0, #5
    tick();
    bus.ImmSrc = 2'b00;
    alu_view(2'b00, 2'b01, 3'b000);
    chk("add_res",   bus.Adr,      32'd12);
    chk("add_flags", bus.ALUFlags, 4'b0000);
    tick();
    idle();
    bus.ResultSrc = 2'b00;
    bus.AdrSrc    = 1'b1;
    bus.RegWrite  = 1'b1;
    settle();
    chk("wb_aluout", bus.Adr, 32'd12);
    tick();
    idle();
    bus.RegSrc = 2'b10;
    tick();
    chk("wd_r2", bus.WriteData, 32'd12);

    // Extender modes
    bus.ImmSrc = 2'b01;
    alu_view(2'b11, 2'b01, 3'b101);
    chk("ext_01", bus.Adr, 32'd5);
    bus.ImmSrc = 2'b10;
    settle();
    chk("ext_10",       bus.Adr,      32'hFE00_8014);
    chk("ext_10_flags", bus.ALUFlags, 4'b1000);
    bus.ImmSrc = 2'b11;
    settle();
    chk("ext_11", bus.Adr, 32'h0);

    // SUB to zero: ALUOut(12) - WriteData(12)
    bus.ImmSrc = 2'b00;
    alu_view(2'b00, 2'b00, 3'b101);
    tick();
    alu_view(2'b10, 2'b00, 3'b001);
    chk("sub_res",   bus.Adr,      32'h0);
    chk("sub_flags", bus.ALUFlags, 4'b0110);

    // ALUOut = 0x7FFFFFFF, then exercise every ALU op against it
    idle();
    bus.RegSrc   = 2'b10;
    bus.ReadData = 32'h7FFF_FFFF;
    tick();
    bus.ResultSrc = 2'b01;
    bus.RegWrite  = 1'b1;
    tick();
    bus.RegWrite  = 1'b0;
    bus.ResultSrc = 2'b00;
    tick();
    alu_view(2'b00, 2'b00, 3'b101);
    tick();
    alu_view(2'b10, 2'b10, 3'b000);
    chk("ovf_res",   bus.Adr,      32'h8000_0003);
    chk("ovf_flags", bus.ALUFlags, 4'b1001);
    alu_view(2'b10, 2'b10, 3'b001);
    chk("sub4_res",   bus.Adr,      32'h7FFF_FFFB);
    chk("sub4_flags", bus.ALUFlags, 4'b0010);
    alu_view(2'b10, 2'b00, 3'b100);
    chk("eor_flags", bus.ALUFlags, 4'b0100);
    alu_view(2'b10, 2'b10, 3'b010);
    chk("and_res", bus.Adr, 32'd4);
    alu_view(2'b10, 2'b10, 3'b011);
    chk("orr_res", bus.Adr, 32'h7FFF_FFFF);
    alu_view(2'b10, 2'b10, 3'b110);
    chk("op110_flags", bus.ALUFlags, 4'b0100);
    alu_view(2'b11, 2'b10, 3'b001);
    chk("borrow_flags", bus.ALUFlags, 4'b1000);

    // Load path
    idle();
    bus.ReadData = 32'hDEAD_BEEF;
    alu_view(2'b01, 2'b10, 3'b000);
    chk("ld_adr", bus.Adr, 32'h108);
    tick();
    idle();
    bus.ResultSrc = 2'b01;
    bus.AdrSrc    = 1'b1;
    bus.RegWrite  = 1'b1;
    bus.RegSrc    = 2'b10;
    settle();
    chk("ld_data", bus.Adr, 32'hDEAD_BEEF);
    tick();
    bus.RegWrite = 1'b0;
    tick();
    chk("ld_wb", bus.WriteData, 32'hDEAD_BEEF);

    // Write to index 15 is dropped; read of index 15 returns Result
    idle();
    bus.ReadData = 32'hE1A0_F00E;
    bus.IRWrite  = 1'b1;
    tick();
    idle();
    bus.RegWrite = 1'b1;
    bus.RegSrc   = 2'b01;
    alu_view(2'b11, 2'b10, 3'b101);
    chk("r15_instr", bus.Instr, 32'hE1A0_F00E);
    tick();
    idle();
    settle();
    chk("r15_pc_keep", bus.Adr, 32'h104);
    alu_view(2'b00, 2'b11, 3'b000);
    chk("r15_read", bus.Adr, 32'd4);

    // Shifter path: ASR #4 of 0x80000000
    idle();
    bus.ReadData = 32'hE1A0_2240;
    bus.IRWrite  = 1'b1;
    tick();
    idle();
    bus.ReadData = 32'h8000_0000;
    tick();
    bus.ResultSrc = 2'b01;
    bus.RegWrite  = 1'b1;
    tick();
    idle();
    bus.RegSrc = 2'b10;
    tick();
    chk("sh_wd", bus.WriteData, 32'h8000_0000);
    alu_view(2'b00, 2'b00, 3'b101);
    chk("sh_res",   bus.Adr,      exp_sh);
    chk("sh_flags", bus.ALUFlags, 4'b1000);

    // Reset mid-operation with every enable asserted
    bus.ReadData = 32'hFFFF_FFFF;
    bus.RegWrite = 1'b1;
    bus.PCWrite  = 1'b1;
    bus.IRWrite  = 1'b1;
    alu_view(2'b11, 2'b10, 3'b101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    settle();
    chk("mrst_adr",   bus.Adr,       32'h100);
    chk("mrst_instr", bus.Instr,     32'h0);
    chk("mrst_wd",    bus.WriteData, 32'h0);
    bus.ReadData = 32'hE1A0_2240;
    bus.IRWrite  = 1'b1;
    tick();
    idle();
    bus.RegSrc = 2'b10;
    tick();
    chk("mrst_r2", bus.WriteData, 32'h0);
    alu_view(2'b00, 2'b11, 3'b000);
    chk("mrst_r0", bus.Adr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
